// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the maximal-length tap table for widths 2..32.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_W = 2;
  localparam int unsigned LFSR_MAX_W = 32;

  // Fibonacci tap masks (bit i set = stage i+1 feeds the XOR), one primitive polynomial per width
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step; an all-zero input is steered back to SEED.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH = 9,
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] next
);

  localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic fb;

  always_comb begin
    fb   = ^(s & TAPS);
    next = {s[WIDTH-2:0], fb};
    // Lock-up escape: zero would otherwise map to itself forever
    if (s == '0) begin
      next = SEED;
    end
  end

endmodule

// File: rtl/lfsr.sv
// Free-running maximal-length LFSR with enable, zero-guarded seed load and at-seed flag.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic             at_seed
);

  // Reject parameter sets the tap table or the zero-state guard cannot honour
  if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr: WIDTH out of range 2..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be nonzero");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_seed;

  lfsr_step #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_step (
    .s    (state_q),
    .next (step_next)
  );

  assign load_seed = (load_value != '0) ? load_value : SEED;

  // Load outranks enable; with neither the register holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= load_seed;
    end else if (enable) begin
      state_q <= step_next;
    end
  end

  assign state   = state_q;
  assign at_seed = (state_q == SEED);

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for the 9-bit LFSR: sequence, full period, hold, load, async reset, lock-up.
module tb_lfsr;

  localparam int unsigned W = 9;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] state;
  logic         at_seed;

  int errors;
  int checks;

  lfsr #(.WIDTH(W), .SEED(9'h001)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .state      (state),
    .at_seed    (at_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_seq [5] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    reset = 1'b0; enable = 1'b1; load = 1'b0; load_value = '0;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (state !== 9'h001 || at_seed !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d state=%h at_seed=%b want state=001 at_seed=1", i, state, at_seed);
      end
    end
    reset = 1'b1;
    checks++;
    if (state !== 9'h001) begin
      errors++;
      $display("FAIL reset_release state=%h want 001", state);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== exp_seq[i]) begin
        errors++;
        $display("FAIL seq step=%0d state=%h want %h", i + 1, state, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state !== 9'h021) begin
        errors++;
        $display("FAIL hold cyc=%0d state=%h want 021", i, state);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (state !== 9'h042) begin
      errors++;
      $display("FAIL hold_resume state=%h want 042", state);
    end
  endtask

  task automatic test_full_period();
    bit seen [512];
    int bad_zero, bad_dup, bad_flag;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    bad_zero = 0; bad_dup = 0; bad_flag = 0;
    enable = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    enable = 1'b1;
    checks++;
    if (state !== 9'h001 || at_seed !== 1'b1) begin
      errors++;
      $display("FAIL period_start state=%h at_seed=%b want 001/1", state, at_seed);
    end
    seen[1] = 1'b1;
    for (int i = 1; i < 511; i++) begin
      tick();
      if (state === 9'h000) bad_zero++;
      if (seen[int'(state)]) bad_dup++;
      if (at_seed !== 1'b0) bad_flag++;
      seen[int'(state)] = 1'b1;
    end
    checks++;
    if (bad_zero != 0) begin
      errors++;
      $display("FAIL period_zero count=%0d want 0", bad_zero);
    end
    checks++;
    if (bad_dup != 0) begin
      errors++;
      $display("FAIL period_repeat count=%0d want 0", bad_dup);
    end
    checks++;
    if (bad_flag != 0) begin
      errors++;
      $display("FAIL period_at_seed_early count=%0d want 0", bad_flag);
    end
    tick();
    checks++;
    if (state !== 9'h001 || at_seed !== 1'b1) begin
      errors++;
      $display("FAIL period_wrap state=%h at_seed=%b want 001/1", state, at_seed);
    end
  endtask

  task automatic test_load();
    load = 1'b1; load_value = 9'h1A5; enable = 1'b1;
    tick();
    checks++;
    if (state !== 9'h1A5 || at_seed !== 1'b0) begin
      errors++;
      $display("FAIL load state=%h at_seed=%b want 1a5/0", state, at_seed);
    end
    load = 1'b0;
    tick();
    checks++;
    if (state !== 9'h14B) begin
      errors++;
      $display("FAIL load_step state=%h want 14b", state);
    end
    load = 1'b1; load_value = 9'h000;
    tick();
    checks++;
    if (state !== 9'h001 || at_seed !== 1'b1) begin
      errors++;
      $display("FAIL load_zero state=%h at_seed=%b want 001/1", state, at_seed);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (state !== 9'h010) begin
      errors++;
      $display("FAIL async_pre state=%h want 010", state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 9'h001 || at_seed !== 1'b1) begin
      errors++;
      $display("FAIL async_now state=%h at_seed=%b want 001/1", state, at_seed);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (state !== 9'h001) begin
        errors++;
        $display("FAIL async_hold cyc=%0d state=%h want 001", i, state);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 9'h002) begin
      errors++;
      $display("FAIL async_restart state=%h want 002", state);
    end
  endtask

  task automatic test_lockup();
    enable = 1'b0;
    @(negedge clk);
    force dut.state_q = '0;
    #1;
    release dut.state_q;
    #1;
    checks++;
    if (state !== 9'h000 || at_seed !== 1'b0) begin
      errors++;
      $display("FAIL lockup_deposit state=%h at_seed=%b want 000/0", state, at_seed);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (state !== 9'h001) begin
      errors++;
      $display("FAIL lockup_escape state=%h want 001", state);
    end
    tick();
    checks++;
    if (state !== 9'h002) begin
      errors++;
      $display("FAIL lockup_after state=%h want 002", state);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_hold();
    test_full_period();
    test_load();
    test_async_reset();
    test_lockup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr.md
Name: lfsr

Overview:
Free-running, maximal-length Fibonacci LFSR that produces a pseudo-random state word, by default 9 bits wide with period 511. It is the randomness source for game-logic blocks such as computer-player timing and random delays. It has an enable and a synchronous seed-load port. It is guaranteed never to enter or remain in the all-zero lock-up state.

Parameters:
WIDTH, 9, state width in bits; legal range 2..32; the tap mask comes from the package table.
SEED, 1 (WIDTH'b0...01), reset and fallback seed; must be nonzero (elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  advance the LFSR one step this cycle
load  input  1  synchronous seed load; has priority over enable
load_value  input  WIDTH  seed applied when load=1
state  output  WIDTH  current LFSR register value (registered, no combinational path from inputs)
at_seed  output  1  combinational flag, 1 when state == SEED

Behaviour:
- The only storage is a WIDTH-bit register driving state.
- Reset: when reset=0, state is forced to SEED immediately, independent of clk. It holds SEED while reset stays low. at_seed=1 during reset.
- Per rising clk edge, with reset=1:
  - load=1: state <= load_value if it is nonzero, else state <= SEED (zero-load guard). enable is ignored.
  - load=0, enable=1: state <= next(state).
  - load=0, enable=0: state holds.
- Step function next(s) = {s[WIDTH-2:0], fb}, where fb = XOR-reduce(s & TAPS(WIDTH)). This is a left shift; the feedback bit enters at the LSB.
- WIDTH=9 uses TAPS = bits 8 and 4 (polynomial x^9+x^5+1): fb = s[8]^s[4].
- Every table entry is a primitive polynomial, so the period is 2^WIDTH-1. For WIDTH=9, 511 distinct nonzero states are visited and the register returns to SEED exactly 511 enabled steps after leaving it.
- Lock-up guard: if state is ever 0 (illegal, e.g. after an SEU), the next edge with enable=1 or load=1 loads SEED instead.
- Latency: state changes one cycle after enable/load is sampled.
- Reset mid-operation: the sequence restarts from SEED, and the first enabled edge after reset deasserts produces next(SEED).
- Reset deassertion is synchronised by the surrounding system; no internal synchroniser.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_taps(width) returning a 32-bit tap mask for widths 2..32, using a standard maximal-length table;
  - constant LFSR_MIN_W=2;
  - constant LFSR_MAX_W=32.
- One natural combinational sub-module, lfsr_step: WIDTH parameter; input s; output next, including the zero-state guard. The top-level lfsr holds the register, load/enable priority and the at_seed compare.

Test Plan:
1. Hold reset=0 for 2 cycles, then release with enable=1. Required sequence: state=9'h001 during reset and at release; then 9'h002, 9'h004, 9'h008, 9'h010, 9'h021 on successive edges.
2. Full period: enable=1 continuously after reset. Required: 511 distinct states, never 9'h000, state==9'h001 again exactly on step 511, at_seed=1 only at steps 0 and 511.
3. enable=0 for 10 cycles mid-sequence (e.g. at state 9'h021). Required: state holds at 9'h021; the next enabled edge gives 9'h042.
4. load=1, load_value=9'h1A5, enable=1 simultaneously. Required: state=9'h1A5 next cycle. Then load_value=9'h000 with load=1. Required: state=9'h001.
5. Assert reset=0 asynchronously mid-cycle while running. Required: state=9'h001 before the next clk edge and held until release.
6. Force the register to 0 via bench deposit, then apply enable=1. Required: state=9'h001 after one edge.
